multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Main control FSM for the multicycle RV32I core: sequences the shared ALU, the unified
//  instruction/data memory and the register file over several cycles per instruction.
//  Decodes the opcode held in the external instruction register.
//  Drives per-state mux selects, write enables and the ALU operation.
//  Supports LW, SW, R-type ALU, I-type ALU, BEQ/BNE and JAL.
// PARAMETERS
//  ILLEGAL_HALT  0  1: an unknown opcode or branch funct3 parks the FSM in HALT. 0: pulse o_illegal, resume FETCH.
// PORTS
//  i_clk                input  1  sole clock, rising edge
//  i_rst                input  1  asynchronous, active-high reset
//  i_operand            input  7  opcode field of IR (LW 0000011, SW 0100011, R 0110011, I 0010011, B 1100011, JAL 1101111)
//  i_funct3             input  3  IR[14:12]
//  i_funct7bit5         input  1  IR[30]
//  i_zeroFlag           input  1  ALU zero flag, same cycle
//  o_pcWriteEn          output 1  PC register load
//  o_adrSrc             output 1  memory address: 0 PC, 1 ALUOut
//  o_irWriteEn          output 1  load IR and oldPC
//  o_memWriteEn         output 1  memory write
//  o_regWriteEn         output 1  register file write
//  o_aluSrcA            output 2  00 PC, 01 oldPC, 10 rs1 register
//  o_aluSrcB            output 2  00 rs2 register, 01 immExt, 10 constant 4
//  o_resultSrc          output 2  00 ALUOut, 01 data register, 10 ALU result (comb)
//  o_aluLogicOperation  output 4  {funct7bit5,funct3} encoding, ADD=0000, SUB=1000
//  o_illegal            output 1  one-cycle pulse on an illegal instruction
// BEHAVIOUR
//  - Moore outputs decoded from state; o_pcWriteEn in BRANCH is also gated by i_zeroFlag (Mealy).
//  - Reset: state=FETCH. While i_rst=1 all enables and o_illegal are 0, and selects show FETCH values.
//  - Unlisted outputs are 0 in each state. "Enables" means pcWriteEn, irWriteEn, memWriteEn and regWriteEn.
//  - FETCH: adrSrc0 irWr1 srcA00 srcB10 ADD result10 pcWr1 -> DECODE.
//  - DECODE: srcA01 srcB01 ADD (branch/jump target into ALUOut). Next state:
//    - LW/SW -> MEMADR; R -> EXEC_R; I -> EXEC_I; JAL -> JAL.
//    - B with funct3 000/001 -> BRANCH; anything else -> illegal.
//  - MEMADR: srcA10 srcB01 ADD. Next state: LW -> MEMREAD, SW -> MEMWRITE.
//  - MEMREAD: adrSrc1 -> MEMWB.
//  - MEMWB: result01 regWr1 -> FETCH.
//  - MEMWRITE: adrSrc1 result00 memWr1 -> FETCH.
//  - EXEC_R: srcA10 srcB00, op {funct7bit5,funct3} -> ALUWB.
//  - EXEC_I: srcA10 srcB01, op {0,funct3}; for funct3=101 (SRLI/SRAI) op={funct7bit5,101} -> ALUWB.
//  - ALUWB: result00 regWr1 -> FETCH.
//  - BRANCH: srcA10 srcB00 SUB result00 -> FETCH.
//    - pcWr = zero for funct3 000 (BEQ); pcWr = ~zero for funct3 001 (BNE).
//  - JAL: srcA01 srcB10 ADD result00 pcWr1 (PC<=target, ALU computes PC+4) -> ALUWB.
//  - Illegal path, in DECODE:
//    - o_illegal=1 for exactly one cycle.
//    - ILLEGAL_HALT=0: next state FETCH. ILLEGAL_HALT=1: next state HALT.
//  - HALT: all enables 0, selects 0, op ADD; left only via i_rst.
//  - Latency in cycles: LW 5; SW, R, I and JAL 4; BRANCH 3.
//  - IR is stable after FETCH; the FSM does not re-check the opcode except in DECODE and MEMADR.
//  - Reset asserted mid-instruction: state=FETCH immediately (async), no partial write in the reset cycle.
//    - FETCH is the first state clocked after release.
//  - Unreachable state encodings recover to FETCH on the next edge with all enables 0.
// TESTING
//  - Reset during MEMWRITE: memWriteEn falls to 0 with i_rst; FETCH (irWr=1, pcWr=1) on the first edge after release.
//  - LW (0000011): states FETCH,DECODE,MEMADR,MEMREAD,MEMWB.
//    - regWr=1 with result=01 only in the 5th cycle; then FETCH.
//  - R-type SUB (funct3 000, funct7bit5 1): EXEC_R op=1000; ALUWB regWr=1.
//    - I-type SRAI (funct3 101, bit5 1): op=1101. ADDI with bit5=1: op=0000.
//  - BEQ zero=1 -> pcWr=1 in BRANCH; zero=0 -> 0. BNE zero=0 -> 1.
//    - 3 cycles each; memWr and regWr stay 0 throughout.
//  - JAL: pcWr=1 in the JAL state with srcA=01, srcB=10; regWr=1 with result=00 in ALUWB; total 4 cycles.
//  - Opcode 0000000, ILLEGAL_HALT=0: o_illegal=1 in DECODE for one cycle, then FETCH.
//    - ILLEGAL_HALT=1: HALT with all enables 0 for 20 cycles until i_rst.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM sequencing ALU, memory and register file for a multicycle RV32I core
module multicycle_controller #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_operand,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7bit5,
  input  logic       i_zeroFlag,
  output logic       o_pcWriteEn,
  output logic       o_adrSrc,
  output logic       o_irWriteEn,
  output logic       o_memWriteEn,
  output logic       o_regWriteEn,
  output logic [1:0] o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [1:0] o_resultSrc,
  output logic [3:0] o_aluLogicOperation,
  output logic       o_illegal
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_HALT
  } state_t;

  state_t     state_q, state_d;
  logic       pc_we, adr_src, ir_we, mem_we, reg_we, illegal;
  logic [1:0] src_a, src_b, res_src;
  logic [3:0] alu_op;

  // state register; reset forces FETCH immediately
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state_q <= S_FETCH;
    else state_q <= state_d;

  // next state and per-state control decode; BRANCH pc load follows the zero flag
  always_comb begin
    state_d = S_FETCH;
    pc_we   = 1'b0;
    adr_src = 1'b0;
    ir_we   = 1'b0;
    mem_we  = 1'b0;
    reg_we  = 1'b0;
    src_a   = 2'b00;
    src_b   = 2'b00;
    res_src = 2'b00;
    alu_op  = 4'b0000;
    illegal = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_we   = 1'b1;
        src_b   = 2'b10;
        res_src = 2'b10;
        pc_we   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
        case (i_operand)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_JAL:       state_d = S_JAL;
          OP_B:         if (i_funct3[2:1] == 2'b00) state_d = S_BRANCH; else illegal = 1'b1;
          default:      illegal = 1'b1;
        endcase
        if (illegal) state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
      end
      S_MEMADR: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        state_d = (i_operand == OP_LW) ? S_MEMREAD : (i_operand == OP_SW) ? S_MEMWRITE : S_FETCH;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        res_src = 2'b01;
        reg_we  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_we  = 1'b1;
      end
      S_EXEC_R: begin
        src_a   = 2'b10;
        alu_op  = {i_funct7bit5, i_funct3};
        state_d = S_ALUWB;
      end
      S_EXEC_I: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu_op  = {(i_funct3 == 3'b101) & i_funct7bit5, i_funct3};
        state_d = S_ALUWB;
      end
      S_ALUWB: reg_we = 1'b1;
      S_BRANCH: begin
        src_a  = 2'b10;
        alu_op = 4'b1000;
        pc_we  = i_funct3[0] ? ~i_zeroFlag : i_zeroFlag;
      end
      S_JAL: begin
        src_a   = 2'b01;
        src_b   = 2'b10;
        pc_we   = 1'b1;
        state_d = S_ALUWB;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign o_pcWriteEn         = pc_we & ~i_rst;
  assign o_adrSrc            = adr_src;
  assign o_irWriteEn         = ir_we & ~i_rst;
  assign o_memWriteEn        = mem_we & ~i_rst;
  assign o_regWriteEn        = reg_we & ~i_rst;
  assign o_aluSrcA           = src_a;
  assign o_aluSrcB           = src_b;
  assign o_resultSrc         = res_src;
  assign o_aluLogicOperation = alu_op;
  assign o_illegal           = illegal & ~i_rst;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed checks of the multicycle control FSM, resume and halt variants
module tb_multicycle_controller;
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [6:0] i_operand = 7'b0;
  logic [2:0] i_funct3 = 3'b0;
  logic       i_funct7bit5 = 1'b0;
  logic       i_zeroFlag = 1'b0;
  logic       pc0, adr0, ir0, mem0, rg0, ill0, pc1, adr1, ir1, mem1, rg1, ill1;
  logic [1:0] a0, b0, r0, a1, b1, r1;
  logic [3:0] op0, op1;
  logic [15:0] o0, o1;
  int n_chk = 0;
  int n_pass = 0;

  // packed order: pc adr ir mem reg | srcA | srcB | result | op | illegal
  localparam logic [15:0] RST = {5'b00000, 2'b00, 2'b10, 2'b10, 4'b0000, 1'b0};
  localparam logic [15:0] F   = {5'b10100, 2'b00, 2'b10, 2'b10, 4'b0000, 1'b0};
  localparam logic [15:0] D   = {5'b00000, 2'b01, 2'b01, 2'b00, 4'b0000, 1'b0};
  localparam logic [15:0] DI  = {5'b00000, 2'b01, 2'b01, 2'b00, 4'b0000, 1'b1};
  localparam logic [15:0] MA  = {5'b00000, 2'b10, 2'b01, 2'b00, 4'b0000, 1'b0};
  localparam logic [15:0] MR  = {5'b01000, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0};
  localparam logic [15:0] MWB = {5'b00001, 2'b00, 2'b00, 2'b01, 4'b0000, 1'b0};
  localparam logic [15:0] MWR = {5'b01010, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0};
  localparam logic [15:0] ERS = {5'b00000, 2'b10, 2'b00, 2'b00, 4'b1000, 1'b0};
  localparam logic [15:0] EIS = {5'b00000, 2'b10, 2'b01, 2'b00, 4'b1101, 1'b0};
  localparam logic [15:0] EIA = {5'b00000, 2'b10, 2'b01, 2'b00, 4'b0000, 1'b0};
  localparam logic [15:0] AWB = {5'b00001, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0};
  localparam logic [15:0] BRT = {5'b10000, 2'b10, 2'b00, 2'b00, 4'b1000, 1'b0};
  localparam logic [15:0] BRN = {5'b00000, 2'b10, 2'b00, 2'b00, 4'b1000, 1'b0};
  localparam logic [15:0] J   = {5'b10000, 2'b01, 2'b10, 2'b00, 4'b0000, 1'b0};
  localparam logic [15:0] H   = 16'h0000;

  multicycle_controller #(.ILLEGAL_HALT(1'b0)) dut_res (
    .i_clk(i_clk), .i_rst(i_rst), .i_operand(i_operand), .i_funct3(i_funct3),
    .i_funct7bit5(i_funct7bit5), .i_zeroFlag(i_zeroFlag),
    .o_pcWriteEn(pc0), .o_adrSrc(adr0), .o_irWriteEn(ir0), .o_memWriteEn(mem0),
    .o_regWriteEn(rg0), .o_aluSrcA(a0), .o_aluSrcB(b0), .o_resultSrc(r0),
    .o_aluLogicOperation(op0), .o_illegal(ill0));

  multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut_halt (
    .i_clk(i_clk), .i_rst(i_rst), .i_operand(i_operand), .i_funct3(i_funct3),
    .i_funct7bit5(i_funct7bit5), .i_zeroFlag(i_zeroFlag),
    .o_pcWriteEn(pc1), .o_adrSrc(adr1), .o_irWriteEn(ir1), .o_memWriteEn(mem1),
    .o_regWriteEn(rg1), .o_aluSrcA(a1), .o_aluSrcB(b1), .o_resultSrc(r1),
    .o_aluLogicOperation(op1), .o_illegal(ill1));

  assign o0 = {pc0, adr0, ir0, mem0, rg0, a0, b0, r0, op0, ill0};
  assign o1 = {pc1, adr1, ir1, mem1, rg1, a1, b1, r1, op1, ill1};

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic cyc(input string tag, input logic [15:0] exp);
    chk(tag, o0, exp);
    chk({tag, "_halt"}, o1, exp);
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_rst(input string tag);
    i_rst = 1'b1;
    #1;
    chk({tag, "_rst"}, o0, RST);
    chk({tag, "_rst_halt"}, o1, RST);
    #2;
    i_rst = 1'b0;
    #1;
  endtask

  task automatic instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
    i_operand = opc;
    i_funct3 = f3;
    i_funct7bit5 = f7;
  endtask

  initial begin
    @(posedge i_clk);
    #1;
    pulse_rst("init");
    instr(7'b0000011, 3'b010, 1'b0);
    cyc("lw_f", F); cyc("lw_d", D); cyc("lw_ma", MA); cyc("lw_mr", MR); cyc("lw_wb", MWB);
    instr(7'b0100011, 3'b010, 1'b0);
    cyc("sw_f", F); cyc("sw_d", D); cyc("sw_ma", MA); cyc("sw_mw", MWR);
    instr(7'b0110011, 3'b000, 1'b1);
    cyc("sub_f", F); cyc("sub_d", D); cyc("sub_ex", ERS); cyc("sub_wb", AWB);
    instr(7'b0010011, 3'b101, 1'b1);
    cyc("srai_f", F); cyc("srai_d", D); cyc("srai_ex", EIS); cyc("srai_wb", AWB);
    instr(7'b0010011, 3'b000, 1'b1);
    cyc("addi_f", F); cyc("addi_d", D); cyc("addi_ex", EIA); cyc("addi_wb", AWB);
    instr(7'b1100011, 3'b000, 1'b0);
    i_zeroFlag = 1'b1;
    cyc("beq_t_f", F); cyc("beq_t_d", D); cyc("beq_t_br", BRT);
    i_zeroFlag = 1'b0;
    cyc("beq_n_f", F); cyc("beq_n_d", D); cyc("beq_n_br", BRN);
    instr(7'b1100011, 3'b001, 1'b0);
    cyc("bne_f", F); cyc("bne_d", D); cyc("bne_br", BRT);
    i_zeroFlag = 1'b1;
    cyc("bne_n_f", F); cyc("bne_n_d", D); cyc("bne_n_br", BRN);
    i_zeroFlag = 1'b0;
    instr(7'b1101111, 3'b000, 1'b0);
    cyc("jal_f", F); cyc("jal_d", D); cyc("jal_j", J); cyc("jal_wb", AWB);
    instr(7'b1100011, 3'b010, 1'b0);
    cyc("badbr_f", F);
    chk("badbr_d", o0, DI);
    @(posedge i_clk);
    #1;
    chk("badbr_next", o0, F);
    chk("badbr_halt", o1, H);
    pulse_rst("resync0");
    instr(7'b0000000, 3'b000, 1'b0);
    cyc("ill_f", F);
    chk("ill_d", o0, DI);
    chk("ill_d_halt", o1, DI);
    @(posedge i_clk);
    #1;
    chk("ill_next", o0, F);
    instr(7'b0000011, 3'b010, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("halt_%0d", i), o1, H);
      @(posedge i_clk);
      #1;
    end
    pulse_rst("resync1");
    cyc("post_halt_f", F);
    cyc("post_halt_d", D);
    pulse_rst("resync2");
    instr(7'b0100011, 3'b010, 1'b0);
    cyc("swr_f", F); cyc("swr_d", D); cyc("swr_ma", MA);
    chk("swr_mw", o0, MWR);
    pulse_rst("swr");
    cyc("swr_after_f", F);
    cyc("swr_after_d", D);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
